// File: rtl/match_extend_ctrl.sv
// Match-length extension sequencer: issues chunked compare rounds starting past the
// verified prefix, accumulates first-mismatch lengths, and saturates at MAX_MATCH_LEN.
module match_extend_ctrl #(
  parameter int MASK_WIDTH      = 14,
  parameter int MATCH_LEN_WIDTH = 8,
  parameter int MAX_MATCH_LEN   = 255,
  parameter int ADDR_WIDTH      = 16,
  parameter int ROUND_WIDTH     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_WIDTH-1:0]      req_head_addr,
  input  logic [ADDR_WIDTH-1:0]      req_hist_addr,
  input  logic [MATCH_LEN_WIDTH-1:0] req_init_len,
  output logic                       cmp_req_valid,
  input  logic                       cmp_req_ready,
  output logic [ADDR_WIDTH-1:0]      cmp_req_head_addr,
  output logic [ADDR_WIDTH-1:0]      cmp_req_hist_addr,
  input  logic                       cmp_rsp_valid,
  output logic                       cmp_rsp_ready,
  input  logic [MASK_WIDTH-1:0]      cmp_rsp_bitmask,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [MATCH_LEN_WIDTH-1:0] rsp_match_len,
  output logic                       rsp_saturated,
  output logic [ROUND_WIDTH-1:0]     rsp_rounds
);

  localparam int CW = $clog2(MASK_WIDTH + 1);
  localparam logic [MATCH_LEN_WIDTH:0]   MAX_LEN_W = (MATCH_LEN_WIDTH+1)'(MAX_MATCH_LEN);
  localparam logic [MATCH_LEN_WIDTH-1:0] MAX_LEN   = MATCH_LEN_WIDTH'(MAX_MATCH_LEN);
  localparam logic [ADDR_WIDTH-1:0]      STRIDE    = ADDR_WIDTH'(MASK_WIDTH);
  localparam logic [CW-1:0]              FULL_CHK  = CW'(MASK_WIDTH);
  localparam logic [ROUND_WIDTH-1:0]     ROUND_MAX = {ROUND_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [MATCH_LEN_WIDTH-1:0] r_len, w_len_nxt;
  logic                       r_sat, w_sat_nxt;
  logic [ROUND_WIDTH-1:0]     r_rounds, w_rounds_nxt;
  logic [ADDR_WIDTH-1:0]      r_head_ptr, w_head_ptr_nxt;
  logic [ADDR_WIDTH-1:0]      r_hist_ptr, w_hist_ptr_nxt;
  logic [CW-1:0]              w_chunk;
  logic [MATCH_LEN_WIDTH:0]   w_sum;

  // Same first-mismatch rule as the match length encoder: lowest zero bit wins.
  function automatic logic [CW-1:0] first_zero(input logic [MASK_WIDTH-1:0] mask);
    logic [CW-1:0] idx;
    idx = CW'(MASK_WIDTH);
    for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        idx = CW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign w_chunk = first_zero(cmp_rsp_bitmask);
  assign w_sum   = {1'b0, r_len} + (MATCH_LEN_WIDTH+1)'(w_chunk);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_sat_nxt      = r_sat;
    w_rounds_nxt   = r_rounds;
    w_head_ptr_nxt = r_head_ptr;
    w_hist_ptr_nxt = r_hist_ptr;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_rounds_nxt   = {ROUND_WIDTH{1'b0}};
          w_head_ptr_nxt = req_head_addr + ADDR_WIDTH'(req_init_len);
          w_hist_ptr_nxt = req_hist_addr + ADDR_WIDTH'(req_init_len);
          if ({1'b0, req_init_len} >= MAX_LEN_W) begin
            w_len_nxt   = MAX_LEN;
            w_sat_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_len_nxt   = req_init_len;
            w_sat_nxt   = 1'b0;
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmp_req_ready) begin
          w_rounds_nxt = (r_rounds == ROUND_MAX) ? r_rounds : r_rounds + {{(ROUND_WIDTH-1){1'b0}}, 1'b1};
          w_state_nxt  = ST_WAIT;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // Saturation is checked before mismatch so a clamped result is always flagged.
        if (cmp_rsp_valid) begin
          if (w_sum >= MAX_LEN_W) begin
            w_len_nxt   = MAX_LEN;
            w_sat_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end else if (w_chunk < FULL_CHK) begin
            w_len_nxt   = w_sum[MATCH_LEN_WIDTH-1:0];
            w_state_nxt = ST_DONE;
          end else begin
            w_len_nxt      = w_sum[MATCH_LEN_WIDTH-1:0];
            w_head_ptr_nxt = r_head_ptr + STRIDE;
            w_hist_ptr_nxt = r_hist_ptr + STRIDE;
            w_state_nxt    = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= {MATCH_LEN_WIDTH{1'b0}};
      r_sat      <= 1'b0;
      r_rounds   <= {ROUND_WIDTH{1'b0}};
      r_head_ptr <= {ADDR_WIDTH{1'b0}};
      r_hist_ptr <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_sat      <= w_sat_nxt;
      r_rounds   <= w_rounds_nxt;
      r_head_ptr <= w_head_ptr_nxt;
      r_hist_ptr <= w_hist_ptr_nxt;
    end
  end

  assign req_ready         = (r_state == ST_IDLE);
  assign cmp_req_valid     = (r_state == ST_ISSUE);
  assign cmp_rsp_ready     = (r_state == ST_WAIT);
  assign rsp_valid         = (r_state == ST_DONE);
  assign cmp_req_head_addr = r_head_ptr;
  assign cmp_req_hist_addr = r_hist_ptr;
  assign rsp_match_len     = r_len;
  assign rsp_saturated     = r_sat;
  assign rsp_rounds        = r_rounds;

endmodule

// File: tb/tb_match_extend_ctrl.sv
// Directed-vector bench for match_extend_ctrl with hand-computed expected lengths,
// addresses and round counts.
module tb_match_extend_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_head_addr;
  logic [15:0] req_hist_addr;
  logic [7:0]  req_init_len;
  logic        cmp_req_valid;
  logic        cmp_req_ready;
  logic [15:0] cmp_req_head_addr;
  logic [15:0] cmp_req_hist_addr;
  logic        cmp_rsp_valid;
  logic        cmp_rsp_ready;
  logic [13:0] cmp_rsp_bitmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_match_len;
  logic        rsp_saturated;
  logic [4:0]  rsp_rounds;

  int n_vec;
  int n_err;

  match_extend_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_head_addr     (req_head_addr),
    .req_hist_addr     (req_hist_addr),
    .req_init_len      (req_init_len),
    .cmp_req_valid     (cmp_req_valid),
    .cmp_req_ready     (cmp_req_ready),
    .cmp_req_head_addr (cmp_req_head_addr),
    .cmp_req_hist_addr (cmp_req_hist_addr),
    .cmp_rsp_valid     (cmp_rsp_valid),
    .cmp_rsp_ready     (cmp_rsp_ready),
    .cmp_rsp_bitmask   (cmp_rsp_bitmask),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_match_len     (rsp_match_len),
    .rsp_saturated     (rsp_saturated),
    .rsp_rounds        (rsp_rounds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one candidate; returns one cycle after the accepting edge.
  task automatic send_req(input logic [15:0] head, input logic [15:0] hist, input logic [7:0] len);
    check_vec("req_ready_before", 32'(req_ready), 32'd1);
    req_valid     = 1'b1;
    req_head_addr = head;
    req_hist_addr = hist;
    req_init_len  = len;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_round(input logic [15:0] eh, input logic [15:0] ey,
                          input logic [13:0] mask, input int stall);
    check_vec("cmp_req_valid", 32'(cmp_req_valid), 32'd1);
    check_vec("cmp_head", 32'(cmp_req_head_addr), 32'(eh));
    check_vec("cmp_hist", 32'(cmp_req_hist_addr), 32'(ey));
    for (int k = 0; k < stall; k++) begin
      tick();
      check_vec("stall_valid", 32'(cmp_req_valid), 32'd1);
      check_vec("stall_head", 32'(cmp_req_head_addr), 32'(eh));
      check_vec("stall_hist", 32'(cmp_req_hist_addr), 32'(ey));
    end
    cmp_req_ready = 1'b1;
    tick();
    cmp_req_ready = 1'b0;
    check_vec("cmp_rsp_ready", 32'(cmp_rsp_ready), 32'd1);
    check_vec("cmp_req_dropped", 32'(cmp_req_valid), 32'd0);
    cmp_rsp_valid   = 1'b1;
    cmp_rsp_bitmask = mask;
    tick();
    cmp_rsp_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [7:0] elen, input logic esat,
                         input logic [4:0] erounds, input int stall);
    check_vec("rsp_valid", 32'(rsp_valid), 32'd1);
    check_vec("rsp_len", 32'(rsp_match_len), 32'(elen));
    check_vec("rsp_sat", 32'(rsp_saturated), 32'(esat));
    check_vec("rsp_rounds", 32'(rsp_rounds), 32'(erounds));
    for (int k = 0; k < stall; k++) begin
      tick();
      check_vec("hold_valid", 32'(rsp_valid), 32'd1);
      check_vec("hold_len", 32'(rsp_match_len), 32'(elen));
      check_vec("hold_sat", 32'(rsp_saturated), 32'(esat));
      check_vec("hold_rounds", 32'(rsp_rounds), 32'(erounds));
      check_vec("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_vec("req_ready_after", 32'(req_ready), 32'd1);
    check_vec("rsp_valid_after", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_vec({tag, "_cmp_req_valid"}, 32'(cmp_req_valid), 32'd0);
    check_vec({tag, "_cmp_rsp_ready"}, 32'(cmp_rsp_ready), 32'd0);
    check_vec({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_vec({tag, "_len"}, 32'(rsp_match_len), 32'd0);
    check_vec({tag, "_sat"}, 32'(rsp_saturated), 32'd0);
    check_vec({tag, "_rounds"}, 32'(rsp_rounds), 32'd0);
    check_vec({tag, "_head"}, 32'(cmp_req_head_addr), 32'd0);
    check_vec({tag, "_hist"}, 32'(cmp_req_hist_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_head_addr   = 16'h0000;
    req_hist_addr   = 16'h0000;
    req_init_len    = 8'd0;
    cmp_req_ready   = 1'b0;
    cmp_rsp_valid   = 1'b0;
    cmp_rsp_bitmask = 14'h0000;
    rsp_ready       = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single-round mismatch: mask 0x0007 -> chunk 3, 3+3 = 6.
    send_req(16'h0100, 16'h0040, 8'd3);
    do_round(16'h0103, 16'h0043, 14'h0007, 0);
    get_rsp(8'd6, 1'b0, 5'd1, 0);

    // Multi-round: 14 + 14 + 5 = 33.
    send_req(16'h2000, 16'h1000, 8'd0);
    do_round(16'h2000, 16'h1000, 14'h3FFF, 0);
    do_round(16'h200E, 16'h100E, 14'h3FFF, 0);
    do_round(16'h201C, 16'h101C, 14'h001F, 0);
    get_rsp(8'd33, 1'b0, 5'd3, 0);

    // Saturation after one full round: 250 + 14 clamps to 255.
    send_req(16'h0300, 16'h0200, 8'd250);
    do_round(16'h03FA, 16'h02FA, 14'h3FFF, 0);
    get_rsp(8'd255, 1'b1, 5'd1, 0);

    // Sum landing exactly on 255 with a mismatch still reports saturation.
    send_req(16'h0300, 16'h0200, 8'd250);
    do_round(16'h03FA, 16'h02FA, 14'h001F, 0);
    get_rsp(8'd255, 1'b1, 5'd1, 0);

    // Init length already at the limit: straight to DONE, no compare.
    send_req(16'h0400, 16'h0500, 8'd255);
    check_vec("sat_init_no_cmp", 32'(cmp_req_valid), 32'd0);
    get_rsp(8'd255, 1'b1, 5'd0, 0);

    // Address wrap with request and response backpressure; mask 0x0001 -> chunk 1.
    send_req(16'hFFFA, 16'h0010, 8'd10);
    do_round(16'h0004, 16'h001A, 14'h0001, 5);
    get_rsp(8'd11, 1'b0, 5'd1, 3);

    // Immediate mismatch at byte 0 adds nothing.
    send_req(16'h0050, 16'h0060, 8'd7);
    do_round(16'h0057, 16'h0067, 14'h0000, 0);
    get_rsp(8'd7, 1'b0, 5'd1, 0);

    // Asynchronous reset while waiting for a compare response.
    send_req(16'h0100, 16'h0200, 8'd5);
    cmp_req_ready = 1'b1;
    tick();
    cmp_req_ready = 1'b0;
    check_vec("pre_reset_wait", 32'(cmp_rsp_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Stray compare response in IDLE must be ignored.
    cmp_rsp_valid   = 1'b1;
    cmp_rsp_bitmask = 14'h0000;
    tick();
    cmp_rsp_valid = 1'b0;
    check_vec("stray_req_ready", 32'(req_ready), 32'd1);
    check_vec("stray_cmp_req", 32'(cmp_req_valid), 32'd0);
    check_vec("stray_rsp_valid", 32'(rsp_valid), 32'd0);

    send_req(16'h0010, 16'h0020, 8'd2);
    do_round(16'h0012, 16'h0022, 14'h0003, 0);
    get_rsp(8'd4, 1'b0, 5'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/match_extend_ctrl.md
# match_extend_ctrl

Sequencer for iterative match-length extension in the match path. It accepts one candidate match: a head address, a history address and an already-verified length. It then issues MASK_WIDTH-byte compare requests to the shared compare unit. Each returned compare bitmask is converted to a per-chunk length with the same first-mismatch rule as the match length encoder, and the result is accumulated. Extension stops on a mismatch or when the length saturates, and the final length is returned to the match selection stage.

## Interface

**Parameters**
- MASK_WIDTH, 14: bytes compared per round; width of the compare bitmask.
- MATCH_LEN_WIDTH, 8: width of the accumulated length.
- MAX_MATCH_LEN, 255: saturation length. Must be ≤ 2^MATCH_LEN_WIDTH−1.
- ADDR_WIDTH, 16: width of the head and history byte addresses.
- ROUND_WIDTH, 5: width of the compare-round counter.

**Ports**
- clk, input, 1: the only clock.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: candidate valid.
- req_ready, output, 1: high exactly when the FSM is in IDLE.
- req_head_addr, input, ADDR_WIDTH: head (lookahead) address.
- req_hist_addr, input, ADDR_WIDTH: history address.
- req_init_len, input, MATCH_LEN_WIDTH: length already verified.
- cmp_req_valid, output, 1: compare request valid.
- cmp_req_ready, input, 1: compare request accepted.
- cmp_req_head_addr, output, ADDR_WIDTH: head address of the chunk.
- cmp_req_hist_addr, output, ADDR_WIDTH: history address of the chunk.
- cmp_rsp_valid, input, 1: compare result valid.
- cmp_rsp_ready, output, 1: high exactly in WAIT.
- cmp_rsp_bitmask, input, MASK_WIDTH: bit i = 1 means byte i matched.
- rsp_valid, output, 1: result valid.
- rsp_ready, input, 1: result accepted.
- rsp_match_len, output, MATCH_LEN_WIDTH: final length.
- rsp_saturated, output, 1: length was clamped to MAX_MATCH_LEN.
- rsp_rounds, output, ROUND_WIDTH: number of compare rounds issued. Saturates at all-ones.

## Operation

**States:** IDLE, ISSUE, WAIT, DONE.

**IDLE**
- req_ready = 1.
- On req_valid & req_ready:
  - len ← req_init_len; rounds ← 0.
  - Head pointer ← req_head_addr + req_init_len; history pointer ← req_hist_addr + req_init_len. Both are modulo 2^ADDR_WIDTH.
  - If req_init_len ≥ MAX_MATCH_LEN: len ← MAX_MATCH_LEN, saturated ← 1, go to DONE. No compare is issued.
  - Otherwise saturated ← 0, go to ISSUE.

**ISSUE**
- cmp_req_valid = 1, with the pointers on the cmp_req_*_addr outputs.
- The outputs stay stable until cmp_req_ready.
- On the handshake: rounds ← rounds+1 (saturating), go to WAIT.

**WAIT**
- cmp_rsp_ready = 1.
- On cmp_rsp_valid:
  - chunk = index of the lowest zero bit of cmp_rsp_bitmask, or MASK_WIDTH if the mask is all ones.
  - sum = len + chunk, computed MATCH_LEN_WIDTH+1 bits wide.
  - If sum ≥ MAX_MATCH_LEN: len ← MAX_MATCH_LEN, saturated ← 1, go to DONE.
  - Else if chunk < MASK_WIDTH: len ← sum, go to DONE.
  - Else: len ← sum, both pointers += MASK_WIDTH (wrapping), go to ISSUE.

**DONE**
- rsp_valid = 1; rsp_* hold len, saturated and rounds, stable until rsp_ready.
- On rsp_ready, go to IDLE.

**Boundary and error rules**
- The saturation test takes priority over the mismatch test.
- cmp_rsp_valid outside WAIT is ignored. The upstream block must not send it.
- Only one compare is ever outstanding.
- Reset mid-operation returns the FSM to IDLE immediately, and the in-flight candidate is discarded. The compare unit must share rst_n so that no stale response survives the reset.

## Timing

**Reset values**
- State = IDLE, so req_ready = 1.
- cmp_req_valid = 0, cmp_rsp_ready = 0, rsp_valid = 0.
- rsp_match_len = 0, rsp_saturated = 0, rsp_rounds = 0.
- Address outputs = 0.

**Registering**
- All outputs are decoded from registered state or come directly from registers.
- There is no combinational path from any input to any output.

**Latency**
- Request accepted at cycle T → cmp_req_valid at T+1.
- Saturation at accept → rsp_valid at T+1.
- Compare response at cycle R → cmp_req_valid (next round) or rsp_valid at R+1.
- A DONE→IDLE handshake at cycle D gives req_ready at D+1.
- Best-case throughput: one candidate every 4 cycles, assuming a single round with zero-wait compare.

## Test plan

1. **Single-round mismatch.** Init_len=3, head=0x0100, hist=0x0040. Expect the compare issued at addresses 0x0103/0x0043. Response bitmask 0x0007 → rsp_match_len=6, saturated=0, rounds=1.
2. **Multi-round extension.** Init_len=0. Masks 0x3FFF, 0x3FFF, 0x001F → rsp_match_len=33, rounds=3. Head addresses issued are +0, +14, +28.
3. **Saturation.** Init_len=250, mask 0x3FFF → rsp_match_len=255, saturated=1, rounds=1. A second test with init_len=255 gives immediate DONE with rounds=0 and no cmp_req_valid.
4. **Backpressure and address wrap.**
   - Hold cmp_req_ready=0 for 5 cycles: the address outputs stay stable.
   - Hold rsp_ready=0 for 3 cycles: rsp_* stays stable and req_ready stays 0.
   - Head=0xFFFA, init_len=10 → first compare at 0x0004.
5. **Reset mid-operation.** Drop rst_n while in WAIT: all outputs return to their reset values asynchronously. After release, a new request completes correctly, and a stray cmp_rsp_valid delivered in IDLE has no effect.
